// File: rtl/ps2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : ps2_pkg                                                    |
// | Description : PS/2 set-2 scancode constants and key-tracker parser state |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;

    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_LEFT  = 8'h6B;   // E0-prefixed
    localparam logic [7:0] SC_RIGHT = 8'h74;   // E0-prefixed

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } parser_state_t;

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_repeat_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ps2_repeat_timer                                           |
// | Description : Single auto-repeat engine following the most recently     |
// |               pressed tracked key (used with PS2_KEY_AUTOREPEAT_EN).     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module ps2_repeat_timer #(
    parameter int unsigned NUM_KEYS      = 8,
    parameter int unsigned REPEAT_DELAY  = 12500000,
    parameter int unsigned REPEAT_PERIOD = 2500000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clear,
    input  logic [NUM_KEYS-1:0] i_load_vec,
    input  logic [NUM_KEYS-1:0] i_break_vec,
    output logic [NUM_KEYS-1:0] o_fire_vec
);

    localparam int unsigned c_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned c_CNT_W = $clog2(c_MAX + 1);
    localparam int unsigned c_IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    logic                r_armed;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_IDX_W-1:0]  r_idx;
    logic                w_load;
    logic [c_IDX_W-1:0]  w_load_idx;
    logic                w_target_break;
    logic                w_fire;

    // Lowest matching index wins when duplicate codes press together
    always_comb begin
        w_load_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (i_load_vec[i]) begin
                w_load_idx = c_IDX_W'(i);
            end
        end
    end

    assign w_load         = |i_load_vec;
    assign w_target_break = r_armed && i_break_vec[r_idx];
    // Expiry edge doubles as reload edge, so the pulse lands exactly
    // REPEAT_DELAY / REPEAT_PERIOD cycles apart.
    assign w_fire         = r_armed && (r_count == c_CNT_W'(1)) && !w_target_break && !i_clear;

    always_comb begin
        o_fire_vec = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            o_fire_vec[i] = w_fire && (r_idx == c_IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
            r_count <= '0;
            r_idx   <= '0;
        end else if (i_clear) begin
            r_armed <= 1'b0;
        end else if (w_load) begin
            r_armed <= 1'b1;
            r_idx   <= w_load_idx;
            r_count <= c_CNT_W'(REPEAT_DELAY);
        end else if (w_target_break) begin
            r_armed <= 1'b0;
        end else if (r_armed) begin
            if (r_count == c_CNT_W'(1)) begin
                r_count <= c_CNT_W'(REPEAT_PERIOD);
            end else begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

endmodule : ps2_repeat_timer
`default_nettype wire

// File: rtl/ps2_key_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ps2_key_tracker                                            |
// | Description : Decodes PS/2 make/break/extended sequences into a per-key  |
// |               held bitmap with press/release pulses. Optional            |
// |               auto-repeat via macro PS2_KEY_AUTOREPEAT_EN.               |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int unsigned          NUM_KEYS      = 8,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES    = {1'b0, SC_BKSP, 1'b0, SC_ENTER,
                                                     1'b1, SC_RIGHT, 1'b1, SC_LEFT,
                                                     1'b0, SC_W, 1'b0, SC_S,
                                                     1'b0, SC_D, 1'b0, SC_A},
    parameter int unsigned          REPEAT_DELAY  = 12500000,
    parameter int unsigned          REPEAT_PERIOD = 2500000
) (
    input  logic                CLOCK_50,
    input  logic                Resetn,
    input  logic [7:0]          received_data,
    input  logic                received_data_en,
    input  logic                clear_keys,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [8:0]          last_code
);

    parser_state_t       r_state;
    parser_state_t       w_state_nxt;
    logic                w_make;
    logic                w_break;
    logic                w_ext;
    logic [NUM_KEYS-1:0] w_match;
    logic [NUM_KEYS-1:0] w_new_press;
    logic [NUM_KEYS-1:0] w_release;
    logic [NUM_KEYS-1:0] w_repeat_vec;
    logic [NUM_KEYS-1:0] r_held;
    logic [NUM_KEYS-1:0] r_press;
    logic [NUM_KEYS-1:0] r_release;
    logic [8:0]          r_last_code;

    always_comb begin
        w_state_nxt = r_state;
        w_make      = 1'b0;
        w_break     = 1'b0;
        w_ext       = 1'b0;
        if (received_data_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (received_data == SC_EXT) begin
                        w_state_nxt = ST_EXT;
                    end else if (received_data == SC_BREAK) begin
                        w_state_nxt = ST_BRK;
                    end else if (received_data != SC_PAUSE) begin
                        w_make = 1'b1;
                    end
                end
                ST_EXT: begin
                    w_ext = 1'b1;
                    if (received_data == SC_BREAK) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else if (received_data != SC_EXT) begin
                        w_make      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    w_ext       = (r_state == ST_EXT_BRK);
                    w_state_nxt = ST_IDLE;
                    w_break     = (received_data != SC_EXT) && (received_data != SC_BREAK);
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
        // A coincident byte is discarded along with any partial sequence
        if (clear_keys) begin
            w_state_nxt = ST_IDLE;
            w_make      = 1'b0;
            w_break     = 1'b0;
        end
    end

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_match
        assign w_match[gi] = (KEY_CODES[gi*9 +: 9] == {w_ext, received_data});
    end

    assign w_new_press = {NUM_KEYS{w_make}}  & w_match & ~r_held;
    assign w_release   = {NUM_KEYS{w_break}} & w_match &  r_held;

`ifdef PS2_KEY_AUTOREPEAT_EN
    ps2_repeat_timer #(
        .NUM_KEYS      (NUM_KEYS),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_repeat_timer (
        .clk         (CLOCK_50),
        .rst_n       (Resetn),
        .i_clear     (clear_keys),
        .i_load_vec  (w_new_press),
        .i_break_vec (w_release),
        .o_fire_vec  (w_repeat_vec)
    );
`else
    assign w_repeat_vec = '0;
`endif

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_state     <= ST_IDLE;
            r_held      <= '0;
            r_press     <= '0;
            r_release   <= '0;
            r_last_code <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_release <= w_release;
            if (clear_keys) begin
                r_held  <= '0;
                r_press <= '0;
            end else begin
                r_held  <= (r_held | w_new_press) & ~w_release;
                r_press <= w_new_press | w_repeat_vec;
            end
            if (w_make) begin
                r_last_code <= {w_ext, received_data};
            end
        end
    end

    assign key_held    = r_held;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign last_code   = r_last_code;

endmodule : ps2_key_tracker
`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ps2_key_tracker                                         |
// | Description : Self-checking bench for ps2_key_tracker (vector table,     |
// |               scoreboard queue, reset/clear/auto-repeat sequences).      |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_ps2_key_tracker;

    logic       clk;
    logic       rst_n;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       clear_keys;
    logic [7:0] key_held;
    logic [7:0] key_press;
    logic [7:0] key_release;
    logic [8:0] last_code;

    int n_cmp = 0;
    int n_err = 0;

    ps2_key_tracker #(
        .NUM_KEYS      (8),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (4)
    ) dut (
        .CLOCK_50         (clk),
        .Resetn           (rst_n),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .clear_keys       (clear_keys),
        .key_held         (key_held),
        .key_press        (key_press),
        .key_release      (key_release),
        .last_code        (last_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       clr;
        logic [7:0] data;
        logic [7:0] held;
        logic [7:0] press;
        logic [7:0] rel;
        logic [8:0] last;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   exp_q[$];

    function automatic void v(input logic en, input logic clr, input logic [7:0] data,
                              input logic [7:0] held, input logic [7:0] press,
                              input logic [7:0] rel, input logic [8:0] last);
        vec_t t;
        t.en = en; t.clr = clr; t.data = data;
        t.held = held; t.press = press; t.rel = rel; t.last = last;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One stimulus cycle, result check one cycle later, then an idle cycle
    // proving pulses last exactly one cycle.
    task automatic apply(input vec_t t, input string tag);
        vec_t e;
        @(negedge clk);
        received_data_en = t.en;
        clear_keys       = t.clr;
        received_data    = t.data;
        sb.push_back(t);
        @(negedge clk);
        received_data_en = 1'b0;
        clear_keys       = 1'b0;
        e = sb.pop_front();
        chk({tag, " held"},    32'(key_held),    32'(e.held));
        chk({tag, " press"},   32'(key_press),   32'(e.press));
        chk({tag, " release"}, 32'(key_release), 32'(e.rel));
        chk({tag, " last"},    32'(last_code),   32'(e.last));
        @(negedge clk);
        chk({tag, " press gone"},   32'(key_press),   32'h0);
        chk({tag, " release gone"}, 32'(key_release), 32'h0);
        chk({tag, " held steady"},  32'(key_held),    32'(e.held));
    endtask

    task automatic send(input logic [7:0] b, input logic [7:0] held, input logic [7:0] press,
                        input logic [7:0] rel, input logic [8:0] last, input string tag);
        vec_t t;
        t.en = 1'b1; t.clr = 1'b0; t.data = b;
        t.held = held; t.press = press; t.rel = rel; t.last = last;
        apply(t, tag);
    endtask

    initial begin
        int n_p;
        int n_r;
        rst_n            = 1'b0;
        received_data    = 8'h00;
        received_data_en = 1'b0;
        clear_keys       = 1'b0;

        //  en clr data   held   press  rel    last
        v(1, 0, 8'h1C, 8'h01, 8'h01, 8'h00, 9'h01C);  // A make
        v(1, 0, 8'hF0, 8'h01, 8'h00, 8'h00, 9'h01C);
        v(1, 0, 8'h1C, 8'h00, 8'h00, 8'h01, 9'h01C);  // A break
        v(1, 0, 8'hE0, 8'h00, 8'h00, 8'h00, 9'h01C);
        v(1, 0, 8'h6B, 8'h10, 8'h10, 8'h00, 9'h16B);  // Left make
        v(1, 0, 8'h1C, 8'h11, 8'h01, 8'h00, 9'h01C);
        v(1, 0, 8'hE0, 8'h11, 8'h00, 8'h00, 9'h01C);
        v(1, 0, 8'hF0, 8'h11, 8'h00, 8'h00, 9'h01C);
        v(1, 0, 8'h6B, 8'h01, 8'h00, 8'h10, 9'h01C);  // Left break
        v(1, 0, 8'h1C, 8'h01, 8'h00, 8'h00, 9'h01C);  // typematic
        v(1, 0, 8'h1C, 8'h01, 8'h00, 8'h00, 9'h01C);
        v(1, 0, 8'hF0, 8'h01, 8'h00, 8'h00, 9'h01C);
        v(1, 0, 8'h1C, 8'h00, 8'h00, 8'h01, 9'h01C);
        v(1, 0, 8'h15, 8'h00, 8'h00, 8'h00, 9'h015);  // untracked Q
        v(1, 0, 8'hF0, 8'h00, 8'h00, 8'h00, 9'h015);
        v(1, 0, 8'hF0, 8'h00, 8'h00, 8'h00, 9'h015);  // malformed break
        v(1, 0, 8'h23, 8'h02, 8'h02, 8'h00, 9'h023);  // D make after recovery
        v(1, 0, 8'hF0, 8'h02, 8'h00, 8'h00, 9'h023);
        v(1, 0, 8'h23, 8'h00, 8'h00, 8'h02, 9'h023);
        v(1, 0, 8'hE0, 8'h00, 8'h00, 8'h00, 9'h023);
        v(1, 0, 8'h74, 8'h20, 8'h20, 8'h00, 9'h174);  // Right make
        v(1, 0, 8'h74, 8'h20, 8'h00, 8'h00, 9'h074);  // non-ext 74 untracked
        v(1, 0, 8'hE1, 8'h20, 8'h00, 8'h00, 9'h074);  // pause prefix ignored
        v(1, 0, 8'hE0, 8'h20, 8'h00, 8'h00, 9'h074);
        v(1, 0, 8'hF0, 8'h20, 8'h00, 8'h00, 9'h074);
        v(1, 0, 8'h74, 8'h00, 8'h00, 8'h20, 9'h074);  // Right break
        v(1, 0, 8'hF0, 8'h00, 8'h00, 8'h00, 9'h074);
        v(1, 0, 8'h1D, 8'h00, 8'h00, 8'h00, 9'h074);  // break of unheld W
        v(1, 0, 8'hE0, 8'h00, 8'h00, 8'h00, 9'h074);
        v(1, 0, 8'hE0, 8'h00, 8'h00, 8'h00, 9'h074);  // repeated E0 stays EXT
        v(1, 0, 8'h6B, 8'h10, 8'h10, 8'h00, 9'h16B);
        v(1, 0, 8'hE0, 8'h10, 8'h00, 8'h00, 9'h16B);
        v(1, 0, 8'hF0, 8'h10, 8'h00, 8'h00, 9'h16B);
        v(1, 0, 8'hE0, 8'h10, 8'h00, 8'h00, 9'h16B);  // malformed ext break
        v(1, 0, 8'h6B, 8'h10, 8'h00, 8'h00, 9'h06B);  // now plain 6B
        v(1, 0, 8'hE0, 8'h10, 8'h00, 8'h00, 9'h06B);
        v(1, 0, 8'hF0, 8'h10, 8'h00, 8'h00, 9'h06B);
        v(1, 0, 8'h6B, 8'h00, 8'h00, 8'h10, 9'h06B);
        v(1, 0, 8'h5A, 8'h40, 8'h40, 8'h00, 9'h05A);  // Enter make
        v(0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 9'h05A);  // clear: no release
        v(1, 0, 8'hE0, 8'h00, 8'h00, 8'h00, 9'h05A);
        v(0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 9'h05A);  // clear aborts EXT
        v(1, 0, 8'h6B, 8'h00, 8'h00, 8'h00, 9'h06B);
        v(1, 0, 8'h1D, 8'h08, 8'h08, 8'h00, 9'h01D);  // W make
        v(1, 1, 8'hF0, 8'h00, 8'h00, 8'h00, 9'h01D);  // clear drops F0
        v(1, 0, 8'h1D, 8'h08, 8'h08, 8'h00, 9'h01D);  // so 1D is a make
        v(1, 1, 8'h1C, 8'h00, 8'h00, 8'h00, 9'h01D);  // clear drops make

        repeat (3) @(negedge clk);
        chk("reset held",    32'(key_held),    32'h0);
        chk("reset press",   32'(key_press),   32'h0);
        chk("reset release", 32'(key_release), 32'h0);
        chk("reset last",    32'(last_code),   32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Asynchronous reset in the middle of an extended sequence
        send(8'h1C, 8'h01, 8'h01, 8'h00, 9'h01C, "rst pre A");
        send(8'hE0, 8'h01, 8'h00, 8'h00, 9'h01C, "rst pre E0");
        #2 rst_n = 1'b0;
        #1;
        chk("async held",    32'(key_held),    32'h0);
        chk("async press",   32'(key_press),   32'h0);
        chk("async release", 32'(key_release), 32'h0);
        chk("async last",    32'(last_code),   32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h6B, 8'h00, 8'h00, 8'h00, 9'h06B, "post rst 6B");

        // Hold D and watch press pulses; break must stop them
`ifdef PS2_KEY_AUTOREPEAT_EN
        for (int k = 1; k <= 40; k++) begin
            if (k == 1 || (k >= 11 && (k - 11) % 4 == 0)) exp_q.push_back(k);
        end
`else
        exp_q.push_back(1);
`endif
        @(negedge clk);
        received_data_en = 1'b1;
        received_data    = 8'h23;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            received_data_en = 1'b0;
            if (key_press != 8'h00) begin
                chk($sformatf("hold press vec k=%0d", k), 32'(key_press), 32'h02);
                if (exp_q.size() == 0) chk("hold press extra cycle", k, 0);
                else chk("hold press cycle", k, exp_q.pop_front());
            end
        end
        chk("hold press missing", exp_q.size(), 0);
        chk("hold held", 32'(key_held), 32'h02);

        n_p = 0;
        n_r = 0;
        @(negedge clk);
        received_data_en = 1'b1;
        received_data    = 8'hF0;
        if (key_press != 8'h00) n_p++;
        @(negedge clk);
        received_data    = 8'h23;
        if (key_press != 8'h00) n_p++;
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            received_data_en = 1'b0;
            if (key_press != 8'h00) n_p++;
            if (key_release == 8'h02) n_r++;
        end
        chk("break press count", n_p, 0);
        chk("break release count", n_r, 1);
        chk("break held", 32'(key_held), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ps2_key_tracker
`default_nettype wire
